// File: rtl/deadlock_report_scheduler.sv
// Round-robin sequencer for dataflow deadlock detectors: launches a trace, captures the cycle, reports it.
// Optional trace watchdog enabled by defining DEADLOCK_TRACE_TIMEOUT_EN.
module deadlock_report_scheduler #(
  parameter int PROC_NUM  = 4,
  parameter int ID_W      = 2,
  parameter int LEN_W     = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_ret_vec,
  input  logic                rearm,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [ID_W-1:0]     report_origin,
  output logic [PROC_NUM-1:0] report_path,
  output logic [LEN_W-1:0]    report_len,
  output logic                report_timeout,
  output logic                deadlock_flag
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_TRACE, S_REPORT, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     origin_q, origin_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PROC_NUM-1:0] path_q, path_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                flag_q, flag_d;

  logic [2*PROC_NUM-1:0] detect_dbl;
  logic [PROC_NUM-1:0]   detect_rot;
  logic [ID_W-1:0]       pick_ofs;
  logic [ID_W:0]         pick_sum;
  logic [ID_W-1:0]       pick_id;
  logic [PROC_NUM-1:0]   origin_onehot;
  logic                  origin_hit;
  logic                  wd_expired;

  // Rotate so rr_ptr sits at bit 0; the lowest set bit is then the round-robin winner.
  always_comb begin
    detect_dbl = {dl_detect_vec, dl_detect_vec} >> rr_ptr_q;
    detect_rot = detect_dbl[PROC_NUM-1:0];
    pick_ofs   = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (detect_rot[i]) pick_ofs = ID_W'(i);
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_ofs};
    if (pick_sum >= (ID_W+1)'(PROC_NUM)) pick_sum = pick_sum - (ID_W+1)'(PROC_NUM);
    pick_id = pick_sum[ID_W-1:0];
  end

  for (genvar gi = 0; gi < PROC_NUM; gi++) begin : g_origin
    assign origin_onehot[gi] = (origin_q == ID_W'(gi));
  end

  assign origin_hit = dl_detect_vec[origin_q];

`ifdef DEADLOCK_TRACE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;

  assign wd_expired = (state_q == S_TRACE) && !origin_hit && (&wd_cnt_q);

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == S_IDLE && |dl_detect_vec) begin
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (state_q == S_TRACE) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_expired) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign report_timeout = timeout_q;
`else
  assign wd_expired     = 1'b0;
  assign report_timeout = 1'b0;
  if (TIMEOUT_W < 1) begin : g_timeout_w_range
  end
`endif

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    rr_ptr_d = rr_ptr_q;
    path_d   = path_q;
    len_d    = len_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: begin
        if (|dl_detect_vec) begin
          origin_d = pick_id;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        path_d  = origin_onehot;
        len_d   = '0;
        state_d = S_TRACE;
      end
      S_TRACE: begin
        if (|token_ret_vec) begin
          path_d = path_q | token_ret_vec;
          if (len_q != '1) len_d = len_q + 1'b1;
        end
        if (origin_hit || wd_expired) begin
          flag_d  = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (report_ready) begin
          rr_ptr_d = (origin_q == ID_W'(PROC_NUM - 1)) ? '0 : origin_q + 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rearm) begin
          path_d  = '0;
          len_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      origin_q <= '0;
      rr_ptr_q <= '0;
      path_q   <= '0;
      len_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      rr_ptr_q <= rr_ptr_d;
      path_q   <= path_d;
      len_q    <= len_d;
      flag_q   <= flag_d;
    end
  end

  assign dl_detect_in  = (state_q != S_IDLE);
  assign origin_vec    = (state_q == S_LAUNCH) ? origin_onehot : '0;
  assign token_clear   = (state_q == S_TRACE) && (origin_hit || wd_expired);
  assign report_valid  = (state_q == S_REPORT);
  assign report_origin = origin_q;
  assign report_path   = path_q;
  assign report_len    = len_q;
  assign deadlock_flag = flag_q;

endmodule

// File: tb/tb_deadlock_report_scheduler.sv
// Bench for deadlock_report_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_deadlock_report_scheduler;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int LW   = 3;
  localparam int TW   = 4;
  localparam int LMAX = (1 << LW) - 1;

  logic           clock;
  logic           reset;
  logic [N-1:0]   dl_detect_vec;
  logic [N-1:0]   token_ret_vec;
  logic           rearm;
  logic           report_ready;
  logic           dl_detect_in;
  logic [N-1:0]   origin_vec;
  logic           token_clear;
  logic           report_valid;
  logic [IDW-1:0] report_origin;
  logic [N-1:0]   report_path;
  logic [LW-1:0]  report_len;
  logic           report_timeout;
  logic           deadlock_flag;

  int total = 0;
  int bad   = 0;

  deadlock_report_scheduler #(
    .PROC_NUM(N), .ID_W(IDW), .LEN_W(LW), .TIMEOUT_W(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .dl_detect_vec(dl_detect_vec), .token_ret_vec(token_ret_vec), .rearm(rearm),
    .dl_detect_in(dl_detect_in), .origin_vec(origin_vec), .token_clear(token_clear),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_origin(report_origin), .report_path(report_path), .report_len(report_len),
    .report_timeout(report_timeout), .deadlock_flag(deadlock_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] sparse_bits();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 7) == 0);
    return b;
  endfunction

  // Behavioural model: phase 0 idle, 1 launch, 2 trace, 3 report, 4 hold.
  int           m_phase;
  int           m_origin;
  int           m_rr;
  int           m_hops;
  int           m_tcyc;
  logic [N-1:0] m_path;
  logic         m_flag;
  logic         m_tmo;

  always begin : compare_proc
    logic         term;
    logic         wd;
    logic [N-1:0] e_oh;
    bit           found;
    @(negedge clock);
    if (!reset) begin
      chk("reset_outputs", {dl_detect_in, origin_vec, token_clear, report_valid, report_origin,
                            report_path, report_len, report_timeout, deadlock_flag}, 32'd0);
      m_phase = 0; m_origin = 0; m_rr = 0; m_hops = 0; m_tcyc = 0;
      m_path = '0; m_flag = 1'b0; m_tmo = 1'b0;
    end else begin
      term = (m_phase == 2) && dl_detect_vec[m_origin];
      wd   = 1'b0;
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
      wd = (m_phase == 2) && !term && (m_tcyc == (1 << TW) - 1);
`endif
      e_oh = '0;
      if (m_phase == 1) e_oh[m_origin] = 1'b1;
      chk("dl_detect_in", dl_detect_in, m_phase != 0);
      chk("origin_vec", origin_vec, e_oh);
      chk("token_clear", token_clear, term || wd);
      chk("report_valid", report_valid, m_phase == 3);
      chk("deadlock_flag", deadlock_flag, m_flag);
      if (m_phase >= 3) begin
        chk("report_origin", report_origin, m_origin);
        chk("report_path", report_path, m_path);
        chk("report_len", report_len, (m_hops > LMAX) ? LMAX : m_hops);
        chk("report_timeout", report_timeout, m_tmo);
      end
      case (m_phase)
        0: if (dl_detect_vec != 0) begin
             found = 0;
             for (int i = 0; i < N; i++) begin
               if (!found && dl_detect_vec[(m_rr + i) % N]) begin
                 m_origin = (m_rr + i) % N;
                 found = 1;
               end
             end
             m_phase = 1;
           end
        1: begin
             m_path = '0;
             m_path[m_origin] = 1'b1;
             m_hops = 0; m_tcyc = 0; m_tmo = 1'b0;
             m_phase = 2;
           end
        2: begin
             if (token_ret_vec != 0) begin
               m_path = m_path | token_ret_vec;
               m_hops++;
             end
             if (term) begin
               m_flag = 1'b1; m_phase = 3;
             end else if (wd) begin
               m_flag = 1'b1; m_tmo = 1'b1; m_phase = 3;
             end else begin
               m_tcyc++;
             end
           end
        3: if (report_ready) begin
             m_rr = (m_origin + 1) % N;
             m_phase = 4;
           end
        default: if (rearm) begin
             m_path = '0; m_hops = 0;
             m_phase = 0;
           end
      endcase
    end
  end

  initial begin
    reset = 1'b0; dl_detect_vec = '0; token_ret_vec = '0; rearm = 1'b0; report_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Cycle 0 -> 2 -> 0
    dl_detect_vec = 4'b0001; tick();
    dl_detect_vec = 4'b0000; tick();
    token_ret_vec = 4'b0100; tick();
    token_ret_vec = 4'b0001; dl_detect_vec = 4'b0001; tick();
    token_ret_vec = 4'b0000; dl_detect_vec = 4'b0000;
    chk("t1_valid", report_valid, 1);
    chk("t1_origin", report_origin, 0);
    chk("t1_path", report_path, 4'b0101);
    chk("t1_len", report_len, 2);
    chk("t1_flag", deadlock_flag, 1);
    report_ready = 1'b1; tick(); report_ready = 1'b0;
    chk("t1_hold_detect", dl_detect_in, 1);
    rearm = 1'b1; tick(); rearm = 1'b0;
    chk("t1_idle_detect", dl_detect_in, 0);

    // Simultaneous detects, round-robin advance
    dl_detect_vec = 4'b1010; tick();
    dl_detect_vec = 4'b0000; tick();
    dl_detect_vec = 4'b0010; tick();
    dl_detect_vec = 4'b0000;
    chk("t2_origin_a", report_origin, 1);
    chk("t2_path_a", report_path, 4'b0010);
    chk("t2_len_a", report_len, 0);
    report_ready = 1'b1; tick(); report_ready = 1'b0;
    rearm = 1'b1; tick(); rearm = 1'b0;
    dl_detect_vec = 4'b1010; tick();
    dl_detect_vec = 4'b0000; tick();
    dl_detect_vec = 4'b1000; tick();
    dl_detect_vec = 4'b0000;

    // Backpressure: five stalled cycles, accept on the sixth
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid_held", report_valid, 1);
      chk("t3_origin_held", report_origin, 3);
      chk("t3_path_held", report_path, 4'b1000);
      chk("t3_flag_held", deadlock_flag, 1);
      tick();
    end
    report_ready = 1'b1; tick(); report_ready = 1'b0;
    chk("t3_hold_detect", dl_detect_in, 1);
    chk("t3_hold_valid", report_valid, 0);
    rearm = 1'b1; tick(); rearm = 1'b0;

    // Reset in the middle of a trace
    dl_detect_vec = 4'b0001; tick();
    dl_detect_vec = 4'b0000; tick();
    token_ret_vec = 4'b0010; tick(); tick();
    token_ret_vec = 4'b0000;
    reset = 1'b0; #1;
    chk("t4_rst_zero", {dl_detect_in, origin_vec, token_clear, report_valid, report_origin,
                        report_path, report_len, report_timeout, deadlock_flag}, 0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("t4_no_report", report_valid, 0);
    chk("t4_flag_cleared", deadlock_flag, 0);

    // Long trace with no return to origin 2
    dl_detect_vec = 4'b0100; tick();
    dl_detect_vec = 4'b0000; tick();
    for (int k = 0; k < 100; k++) begin
      if (k < 4) token_ret_vec = 4'b0001 << k;
      else token_ret_vec = 4'($urandom_range(1, 15));
      dl_detect_vec = sparse_bits() & 4'b1011;
      tick();
    end
    token_ret_vec = 4'b0000; dl_detect_vec = 4'b0000;
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
    chk("t5_timeout_valid", report_valid, 1);
    chk("t5_timeout_flag", report_timeout, 1);
`else
    chk("t5_still_tracing", dl_detect_in, 1);
    chk("t5_no_valid", report_valid, 0);
`endif
    dl_detect_vec = 4'b0100; tick();
    dl_detect_vec = 4'b0000;
    chk("t5_len_sat", report_len, 7);
    chk("t5_path_all", report_path, 4'b1111);
    chk("t5_origin", report_origin, 2);
    report_ready = 1'b1; tick(); report_ready = 1'b0;
    rearm = 1'b1; tick(); rearm = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      dl_detect_vec = sparse_bits();
      token_ret_vec = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      report_ready  = 1'($urandom_range(0, 1));
      rearm         = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1; dl_detect_vec = '0; token_ret_vec = '0; rearm = 1'b0; report_ready = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
